// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt controller. It edge-detects requests into PEND,
// gates them with MASK/GEN, and runs an IDLE/ASSERT/SERVICE handshake with the CPU.
module irq_ctrl #(
  parameter int unsigned N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src_req,
  output logic [N_SRC-1:0] src_clr,
  output logic             irq_o,
  input  logic             irq_ack,
  input  logic [1:0]       addr,
  input  logic             wr_en,
  input  logic [31:0]      din,
  output logic [31:0]      dout
);
  localparam int unsigned ID_W    = 4;
  localparam int unsigned MAX_SRC = 16;
  localparam logic [1:0]  A_PEND  = 2'd0;
  localparam logic [1:0]  A_MASK  = 2'd1;
  localparam logic [1:0]  A_VEC   = 2'd2;
  localparam logic [1:0]  A_CTRL  = 2'd3;

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t           state;
  logic [N_SRC-1:0] pend, mask, req_q;
  logic             gen;
  logic [ID_W-1:0]  cur_id;

  logic [N_SRC-1:0]   rise_c, pend_n, mask_n, cur_oh;
  logic [MAX_SRC-1:0] mask_x;
  logic               gen_n, wr_pend, wr_mask, wr_ctrl, eoi, hit_c, keep_c, take_ack;
  logic [ID_W-1:0]    win_id;

  // Upper write-data bits beyond the source count are intentionally ignored.
  logic unused_din;
  assign unused_din = ^din;

  // Next-value datapath: register writes, edge detect, winner select.
  always_comb begin
    wr_pend  = wr_en && (addr == A_PEND);
    wr_mask  = wr_en && (addr == A_MASK);
    wr_ctrl  = wr_en && (addr == A_CTRL);
    eoi      = wr_en && (addr == A_VEC);
    rise_c   = src_req & ~req_q;
    mask_n   = wr_mask ? din[N_SRC-1:0] : mask;
    gen_n    = wr_ctrl ? din[0] : gen;
    mask_x   = MAX_SRC'(mask_n);
    cur_oh   = N_SRC'(MAX_SRC'(1) << cur_id);
    // Retraction looks at the values being written this cycle so irq_o drops on that edge.
    keep_c   = gen_n && mask_x[cur_id];
    take_ack = (state == ASSERT) && keep_c && irq_ack;
    hit_c    = gen && (|(pend & mask));
    win_id   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pend[i] && mask[i]) win_id = ID_W'(i);
    end
    pend_n = pend;
    if (wr_pend)  pend_n = pend_n & ~din[N_SRC-1:0];
    if (take_ack) pend_n = pend_n & ~cur_oh;
    pend_n = pend_n | rise_c;
  end

  // Register read mux.
  always_comb begin
    dout = '0;
    case (addr)
      A_PEND:  dout = 32'(pend);
      A_MASK:  dout = 32'(mask);
      A_VEC:   dout = 32'({(state == SERVICE), 4'b0000, cur_id});
      default: dout = 32'(gen);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend    <= '0;
      mask    <= '0;
      req_q   <= '0;
      gen     <= 1'b0;
      cur_id  <= '0;
      irq_o   <= 1'b0;
      src_clr <= '0;
    end else begin
      req_q   <= src_req;
      pend    <= pend_n;
      mask    <= mask_n;
      gen     <= gen_n;
      src_clr <= '0;
      case (state)
        IDLE: begin
          if (hit_c) begin
            cur_id <= win_id;
            state  <= ASSERT;
            irq_o  <= 1'b1;
          end
        end
        ASSERT: begin
          if (!keep_c) begin
            state <= IDLE;
            irq_o <= 1'b0;
          end else if (take_ack) begin
            state   <= SERVICE;
            irq_o   <= 1'b0;
            src_clr <= cur_oh;
          end
        end
        SERVICE: begin
          if (eoi) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus a randomized run checked against a
// behavioural model of the controller.
module tb_irq_ctrl;
  localparam int N = 8;
  localparam logic [1:0] M_IDLE = 2'd0, M_ASSERT = 2'd1, M_SERVICE = 2'd2;

  logic          clk, rst_n;
  logic [N-1:0]  src_req, src_clr;
  logic          irq_o, irq_ack, wr_en;
  logic [1:0]    addr;
  logic [31:0]   din, dout, v;
  int            checks = 0, failures = 0;

  typedef struct packed {
    logic [N-1:0] pend, mask, prev, clr;
    logic         gen;
    logic [1:0]   st;
    logic [3:0]   cur;
  } mstate_t;
  mstate_t m;

  irq_ctrl #(.N_SRC(N)) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_clr(src_clr), .irq_o(irq_o),
    .irq_ack(irq_ack), .addr(addr), .wr_en(wr_en), .din(din), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one clock of the controller written straight from the register/handshake rules.
  function automatic mstate_t next_model(input mstate_t s);
    mstate_t n;
    bit found;
    n = s;
    n.clr = '0;
    if (wr_en && addr == 2'd1) n.mask = din[N-1:0];
    if (wr_en && addr == 2'd3) n.gen = din[0];
    if (wr_en && addr == 2'd0) n.pend = s.pend & ~din[N-1:0];
    if (s.st == M_IDLE) begin
      if (s.gen && (s.pend & s.mask) != '0) begin
        found = 0;
        for (int i = 0; i < N; i++)
          if (!found && s.pend[i] && s.mask[i]) begin n.cur = 4'(i); found = 1; end
        n.st = M_ASSERT;
      end
    end else if (s.st == M_ASSERT) begin
      if (!n.gen || !n.mask[s.cur]) n.st = M_IDLE;
      else if (irq_ack) begin
        n.pend[s.cur] = 1'b0;
        n.clr[s.cur]  = 1'b1;
        n.st          = M_SERVICE;
      end
    end else if (wr_en && addr == 2'd2) n.st = M_IDLE;
    n.pend = n.pend | (src_req & ~s.prev);
    n.prev = src_req;
    return n;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m.pend);
      2'd1:    return 32'(m.mask);
      2'd2:    return {23'd0, (m.st == M_SERVICE), 4'd0, m.cur};
      default: return 32'(m.gen);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= next_model(m);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; din = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] r);
    addr = a;
    #1;
    r = dout;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; src_req = '0; irq_ack = 1'b0; wr_en = 1'b0; addr = '0; din = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_req = 8'hFF; irq_ack = 1'b1; wr_en = 1'b1; din = '1;
    #1;
    checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq_o); end
    checks++; if (src_clr !== 8'h00) begin failures++; $display("FAIL reset_clr: got %h want 00", src_clr); end
    tick();
    wr_en = 1'b0; irq_ack = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_reg%0d: got %h want 0", a, v); end
    end
    do_reset();
  endtask

  task automatic test_timer();
    do_reset();
    wr(2'd1, 32'h1); wr(2'd3, 32'h1);
    src_req = 8'h01;
    tick();
    checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL timer_early: got %b want 0", irq_o); end
    tick();
    checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL timer_irq: got %b want 1", irq_o); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; src_req = 8'h00;
    checks++; if (src_clr !== 8'h01) begin failures++; $display("FAIL timer_clr: got %h want 01", src_clr); end
    checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL timer_drop: got %b want 0", irq_o); end
    rd(2'd2, v);
    checks++; if (v !== 32'h100) begin failures++; $display("FAIL timer_vec: got %h want 100", v); end
    rd(2'd0, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL timer_pend: got %h want 0", v); end
    tick();
    checks++; if (src_clr !== 8'h00) begin failures++; $display("FAIL timer_clr_once: got %h want 00", src_clr); end
    wr(2'd2, 32'h0);
    rd(2'd2, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL timer_eoi_vec: got %h want 0", v); end
  endtask

  task automatic test_priority();
    do_reset();
    wr(2'd1, 32'hFF); wr(2'd3, 32'h1);
    src_req = 8'h24;
    tick();
    rd(2'd0, v);
    checks++; if (v !== 32'h24) begin failures++; $display("FAIL prio_pend: got %h want 24", v); end
    tick();
    rd(2'd2, v);
    checks++; if (irq_o !== 1'b1 || v !== 32'h2) begin failures++; $display("FAIL prio_first: got irq=%b vec=%h want irq=1 vec=2", irq_o, v); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; src_req = 8'h20;
    checks++; if (src_clr !== 8'h04) begin failures++; $display("FAIL prio_clr: got %h want 04", src_clr); end
    wr(2'd2, 32'h0);
    checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL prio_eoi_idle: got %b want 0", irq_o); end
    tick();
    rd(2'd2, v);
    checks++; if (irq_o !== 1'b1 || v !== 32'h5) begin failures++; $display("FAIL prio_second: got irq=%b vec=%h want irq=1 vec=5", irq_o, v); end
  endtask

  task automatic test_retract();
    do_reset();
    wr(2'd1, 32'hFF); wr(2'd3, 32'h1);
    src_req = 8'h08;
    tick(); tick();
    rd(2'd2, v);
    checks++; if (irq_o !== 1'b1 || v !== 32'h3) begin failures++; $display("FAIL retract_assert: got irq=%b vec=%h want irq=1 vec=3", irq_o, v); end
    wr(2'd1, 32'h0);
    checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL retract_irq: got %b want 0", irq_o); end
    checks++; if (src_clr !== 8'h00) begin failures++; $display("FAIL retract_clr: got %h want 00", src_clr); end
    rd(2'd0, v);
    checks++; if (v !== 32'h08) begin failures++; $display("FAIL retract_pend: got %h want 08", v); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    rd(2'd2, v);
    checks++; if (src_clr !== 8'h00 || v !== 32'h3) begin failures++; $display("FAIL retract_ack_ignored: got clr=%h vec=%h want clr=00 vec=3", src_clr, v); end
  endtask

  task automatic test_collision();
    do_reset();
    tick();
    src_req = 8'h10;
    wr(2'd0, 32'h10);
    rd(2'd0, v);
    checks++; if (v !== 32'h10) begin failures++; $display("FAIL collide_set_wins: got %h want 10", v); end
    wr(2'd0, 32'h10);
    rd(2'd0, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL collide_w1c: got %h want 0", v); end
  endtask

  task automatic test_reset_service();
    do_reset();
    wr(2'd1, 32'h1); wr(2'd3, 32'h1);
    src_req = 8'h01;
    tick(); tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    tick();
    rd(2'd2, v);
    checks++; if (v !== 32'h100) begin failures++; $display("FAIL rsvc_in_service: got %h want 100", v); end
    rst_n = 1'b0;
    #1;
    checks++; if (irq_o !== 1'b0 || src_clr !== 8'h00) begin failures++; $display("FAIL rsvc_async: got irq=%b clr=%h want 0/00", irq_o, src_clr); end
    tick();
    rst_n = 1'b1;
    rd(2'd1, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rsvc_mask: got %h want 0", v); end
    rd(2'd2, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rsvc_vec: got %h want 0", v); end
    tick();
    rd(2'd0, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL rsvc_first_edge: got %h want 1", v); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++; if (irq_o !== 1'b0 || src_clr !== 8'h00) begin failures++; $display("FAIL rsvc_ack_ignored: got irq=%b clr=%h want 0/00", irq_o, src_clr); end
  endtask

  task automatic test_masked();
    do_reset();
    wr(2'd3, 32'h1);
    src_req = 8'hFF;
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL masked_irq cycle %0d: got %b want 0", c, irq_o); end
    end
    rd(2'd0, v);
    checks++; if (v !== 32'hFF) begin failures++; $display("FAIL masked_pend: got %h want FF", v); end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      checks++; if (irq_o !== (m.st == M_ASSERT)) begin failures++; $display("FAIL rand_irq cycle %0d: got %b want %b", c, irq_o, (m.st == M_ASSERT)); end
      checks++; if (src_clr !== m.clr) begin failures++; $display("FAIL rand_clr cycle %0d: got %h want %h", c, src_clr, m.clr); end
      checks++; if ($countones(src_clr) > 1) begin failures++; $display("FAIL rand_clr_onehot cycle %0d: got %h want at most one bit", c, src_clr); end
      src_req = src_req ^ N'($urandom & $urandom & $urandom);
      irq_ack = ($urandom_range(0, 3) == 0);
      wr_en   = ($urandom_range(0, 4) == 0);
      addr    = 2'($urandom);
      din     = $urandom;
      if (addr == 2'd3 && $urandom_range(0, 3) != 0) din[0] = 1'b1;
      #1;
      exp = m_read(addr);
      checks++; if (dout !== exp) begin failures++; $display("FAIL rand_dout cycle %0d addr %0d: got %h want %h", c, addr, dout, exp); end
      tick();
    end
    wr_en = 1'b0; irq_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; src_req = '0; irq_ack = 1'b0; wr_en = 1'b0; addr = '0; din = '0;
    @(negedge clk);
    test_reset();
    test_timer();
    test_priority();
    test_retract();
    test_collision();
    test_reset_service();
    test_masked();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
